// File: rtl/spi_mode1_slave_rx.sv
// SPI mode-1 (CPOL=0, CPHA=1) receive-only slave.
// Oversamples SCLK/CS/DI on clk, samples DI on each synchronized SCLK falling
// edge and presents completed words on a valid/ready interface. Overrun and
// truncated-frame conditions are reported as one-cycle pulses.
// Build option: define SPI_RX_MSB_FIRST_EN for MSB-first bit order
// (default is LSB-first).
module spi_mode1_slave_rx #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_sclk,
    input  logic              spi_cs,
    input  logic              spi_di,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              busy,
    output logic              overrun,
    output logic              frame_err
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1
    } state_e;

    state_e                  state_q;
    logic [SYNC_STAGES-1:0]  sclk_sync_q;
    logic [SYNC_STAGES-1:0]  cs_sync_q;
    logic [SYNC_STAGES-1:0]  di_sync_q;
    logic                    sclk_prev_q;
    logic                    cs_prev_q;
    logic [CNT_W-1:0]        bit_cnt_q;
    logic [CNT_W-1:0]        bit_cnt_d;
    logic [DATA_W-1:0]       shreg_q;
    logic [DATA_W-1:0]       shreg_d;
    logic                    word_done_q;

    logic sclk_cur_c;
    logic cs_cur_c;
    logic di_cur_c;
    logic sclk_fall_c;
    logic cs_rise_c;
    logic cs_fall_c;

    // Input synchronizer chains plus one delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            di_sync_q   <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
            di_sync_q   <= {di_sync_q[SYNC_STAGES-2:0], spi_di};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    assign sclk_cur_c  = sclk_sync_q[SYNC_STAGES-1];
    assign cs_cur_c    = cs_sync_q[SYNC_STAGES-1];
    assign di_cur_c    = di_sync_q[SYNC_STAGES-1];
    assign sclk_fall_c = sclk_prev_q & ~sclk_cur_c;
    assign cs_rise_c   = ~cs_prev_q & cs_cur_c;
    assign cs_fall_c   = cs_prev_q & ~cs_cur_c;

    // Post-sample shift register and bit count for the current cycle
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        if ((state_q == ST_SHIFT) && sclk_fall_c) begin
`ifdef SPI_RX_MSB_FIRST_EN
            shreg_d = {shreg_q[DATA_W-2:0], di_cur_c};
`else
            shreg_d = {di_cur_c, shreg_q[DATA_W-1:1]};
`endif
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
    end

    // Frame FSM, word hand-off and error pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            word_done_q <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            overrun     <= 1'b0;
            frame_err   <= 1'b0;
            word_done_q <= 1'b0;

            // A word completed last cycle: load it, or drop it if the slot is still full
            if (word_done_q) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shreg_q;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    busy <= 1'b0;
                    if (cs_fall_c) begin
                        state_q   <= ST_SHIFT;
                        busy      <= 1'b1;
                        bit_cnt_q <= '0;
                        shreg_q   <= '0;
                    end
                end
                ST_SHIFT: begin
                    busy      <= 1'b1;
                    shreg_q   <= shreg_d;
                    bit_cnt_q <= bit_cnt_d;
                    if (bit_cnt_d == CNT_W'(DATA_W)) begin
                        word_done_q <= 1'b1;
                        bit_cnt_q   <= '0;
                    end
                    // Sample first, then end the frame using the post-sample count
                    if (cs_rise_c) begin
                        state_q   <= ST_IDLE;
                        busy      <= 1'b0;
                        bit_cnt_q <= '0;
                        if ((bit_cnt_d != '0) && (bit_cnt_d != CNT_W'(DATA_W))) begin
                            frame_err <= 1'b1;
                            shreg_q   <= '0;
                        end
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    busy      <= 1'b0;
                    bit_cnt_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_mode1_slave_rx.sv
// Directed self-checking bench for spi_mode1_slave_rx.
// Honours SPI_RX_MSB_FIRST_EN so the same vectors run in either build.
module tb_spi_mode1_slave_rx;

    localparam int unsigned DATA_W      = 8;
    localparam int unsigned SYNC_STAGES = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              spi_sclk;
    logic              spi_cs;
    logic              spi_di;
    logic              rx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              busy;
    logic              overrun;
    logic              frame_err;

    int total = 0;
    int bad   = 0;

    // Pulse / handshake monitor state (written only by the monitor)
    int   ovr_hi     = 0;
    int   ovr_pulses = 0;
    int   fe_hi      = 0;
    int   fe_pulses  = 0;
    int   busy_low   = 0;
    logic ovr_prev   = 1'b0;
    logic fe_prev    = 1'b0;
    logic [DATA_W-1:0] acc_q[$];

    logic chk_busy = 1'b0;

    spi_mode1_slave_rx #(
        .DATA_W      (DATA_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .spi_sclk  (spi_sclk),
        .spi_cs    (spi_cs),
        .spi_di    (spi_di),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .busy      (busy),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Observe outputs on the falling edge; a handshake seen here completes at the next rising edge
    always @(negedge clk) begin
        if (overrun) ovr_hi++;
        if (overrun && !ovr_prev) ovr_pulses++;
        ovr_prev = overrun;
        if (frame_err) fe_hi++;
        if (frame_err && !fe_prev) fe_pulses++;
        fe_prev = frame_err;
        if (rx_valid && rx_ready) acc_q.push_back(rx_data);
        if (chk_busy && !busy) busy_low++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n clocks; returns 2 time units after the last rising edge
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // k-th transmitted bit of a word in the build's bit order
    function automatic logic bit_at(input logic [DATA_W-1:0] w, input int k);
`ifdef SPI_RX_MSB_FIRST_EN
        return w[DATA_W-1-k];
`else
        return w[k];
`endif
    endfunction

    // One SCLK period: DO changes on the rising edge, half-period 4 clk
    task automatic send_bit(input logic b);
        spi_sclk = 1'b1;
        spi_di   = b;
        cyc(4);
        spi_sclk = 1'b0;
        cyc(4);
    endtask

    task automatic send_word(input logic [DATA_W-1:0] w);
        for (int k = 0; k < DATA_W; k++) send_bit(bit_at(w, k));
    endtask

    task automatic cs_low();
        spi_cs = 1'b0;
        cyc(4);
    endtask

    task automatic cs_high();
        spi_cs = 1'b1;
        cyc(6);
    endtask

    initial begin
        int base_ovr_p, base_ovr_h, base_fe_p, base_fe_h, base_acc;
        logic [DATA_W-1:0] seq;
        logic [DATA_W-1:0] exp_order;

        rst      = 1'b1;
        spi_sclk = 1'b0;
        spi_cs   = 1'b1;
        spi_di   = 1'b0;
        rx_ready = 1'b0;
        cyc(3);
        chk("reset rx_data", 32'(rx_data), 32'h0);
        chk("reset rx_valid", 32'(rx_valid), 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        chk("reset overrun", 32'(overrun), 32'h0);
        chk("reset frame_err", 32'(frame_err), 32'h0);
        rst = 1'b0;
        cyc(4);

        // rx_ready while nothing is valid has no effect
        rx_ready = 1'b1;
        cyc(5);
        chk("idle ready no effect", 32'(rx_valid), 32'h0);
        rx_ready = 1'b0;

        // Single word 8'hB1 with latency check on the last SCLK fall
        base_ovr_p = ovr_pulses;
        base_fe_p  = fe_pulses;
        cs_low();
        chk("busy in frame", 32'(busy), 32'h1);
        for (int k = 0; k < DATA_W - 1; k++) send_bit(bit_at(8'hB1, k));
        spi_sclk = 1'b1;
        spi_di   = bit_at(8'hB1, DATA_W - 1);
        cyc(4);
        spi_sclk = 1'b0;
        cyc(SYNC_STAGES + 1);
        chk("valid not early", 32'(rx_valid), 32'h0);
        cyc(1);
        chk("valid at latency", 32'(rx_valid), 32'h1);
        chk("word B1", 32'(rx_data), 32'hB1);
        cs_high();
        chk("idle after frame", 32'(busy), 32'h0);
        chk("B1 no overrun", 32'(ovr_pulses - base_ovr_p), 32'h0);
        chk("B1 no frame_err", 32'(fe_pulses - base_fe_p), 32'h0);
        rx_ready = 1'b1;
        cyc(1);
        chk("B1 accepted valid drop", 32'(rx_valid), 32'h0);

        // Back-to-back words in one frame with rx_ready held high
        base_acc = acc_q.size();
        base_fe_p = fe_pulses;
        cs_low();
        chk_busy = 1'b1;
        send_word(8'hB1);
        send_word(8'h5A);
        chk_busy = 1'b0;
        cs_high();
        chk("b2b count", 32'(acc_q.size() - base_acc), 32'h2);
        if (acc_q.size() >= base_acc + 2) begin
            chk("b2b word0", 32'(acc_q[base_acc]), 32'hB1);
            chk("b2b word1", 32'(acc_q[base_acc + 1]), 32'h5A);
        end
        chk("b2b busy held", 32'(busy_low), 32'h0);
        chk("b2b no frame_err", 32'(fe_pulses - base_fe_p), 32'h0);
        chk("b2b valid drained", 32'(rx_valid), 32'h0);

        // Overrun: second word is dropped while the first waits
        rx_ready   = 1'b0;
        base_ovr_p = ovr_pulses;
        base_ovr_h = ovr_hi;
        cs_low();
        send_word(8'h11);
        chk("ovr first valid", 32'(rx_valid), 32'h1);
        chk("ovr none yet", 32'(ovr_pulses - base_ovr_p), 32'h0);
        send_word(8'h22);
        cs_high();
        chk("ovr pulses", 32'(ovr_pulses - base_ovr_p), 32'h1);
        chk("ovr width", 32'(ovr_hi - base_ovr_h), 32'h1);
        chk("ovr data kept", 32'(rx_data), 32'h11);
        chk("ovr still valid", 32'(rx_valid), 32'h1);
        base_acc = acc_q.size();
        rx_ready = 1'b1;
        cyc(1);
        chk("ovr accept drop", 32'(rx_valid), 32'h0);
        chk("ovr accept count", 32'(acc_q.size() - base_acc), 32'h1);
        if (acc_q.size() > base_acc) chk("ovr accepted word", 32'(acc_q[base_acc]), 32'h11);
        rx_ready = 1'b0;

        // Truncated frame: 5 bits then CS rises
        base_fe_p = fe_pulses;
        base_fe_h = fe_hi;
        cs_low();
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        cs_high();
        chk("trunc frame_err pulses", 32'(fe_pulses - base_fe_p), 32'h1);
        chk("trunc frame_err width", 32'(fe_hi - base_fe_h), 32'h1);
        chk("trunc no valid", 32'(rx_valid), 32'h0);
        cs_low();
        send_word(8'hC3);
        cs_high();
        chk("after trunc word C3", 32'(rx_data), 32'hC3);
        chk("after trunc valid", 32'(rx_valid), 32'h1);
        chk("after trunc no new err", 32'(fe_pulses - base_fe_p), 32'h1);
        rx_ready = 1'b1;
        cyc(1);
        rx_ready = 1'b0;

        // Reset in the middle of a frame
        base_fe_p  = fe_pulses;
        base_ovr_p = ovr_pulses;
        cs_low();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        rst = 1'b1;
        cyc(1);
        chk("mid rst rx_data", 32'(rx_data), 32'h0);
        chk("mid rst busy", 32'(busy), 32'h0);
        chk("mid rst valid", 32'(rx_valid), 32'h0);
        spi_cs = 1'b1;
        cyc(5);
        chk("mid rst held busy", 32'(busy), 32'h0);
        rst = 1'b0;
        cyc(6);
        chk("post rst busy", 32'(busy), 32'h0);
        chk("post rst valid", 32'(rx_valid), 32'h0);
        cs_low();
        send_word(8'hA5);
        cs_high();
        chk("post rst word A5", 32'(rx_data), 32'hA5);
        chk("post rst valid set", 32'(rx_valid), 32'h1);
        chk("post rst no frame_err", 32'(fe_pulses - base_fe_p), 32'h0);
        chk("post rst no overrun", 32'(ovr_pulses - base_ovr_p), 32'h0);
        rx_ready = 1'b1;
        cyc(1);
        rx_ready = 1'b0;

        // Raw bit order: 1,0,1,1,0,0,0,1 on the wire
        seq = 8'b1011_0001;
`ifdef SPI_RX_MSB_FIRST_EN
        exp_order = 8'hB1;
`else
        exp_order = 8'h8D;
`endif
        cs_low();
        for (int i = DATA_W - 1; i >= 0; i--) send_bit(seq[i]);
        cs_high();
        chk("bit order word", 32'(rx_data), 32'(exp_order));
        chk("bit order valid", 32'(rx_valid), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
